// File: rtl/adder_pkg.sv
// Shared widths, parameter checking and stage payload layout for the pipelined adder.
package adder_pkg;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_STAGES = 4;

  // One pipeline stage at the default geometry: partial sum plus operand slices still to add.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [DEF_WIDTH-1:0] sum;
    logic [DEF_WIDTH-1:0] rem_a;
    logic [DEF_WIDTH-1:0] rem_b;
  } pipe_stage_t;

  // True when WIDTH splits into STAGES equal, non-empty chunks.
  function automatic bit params_ok(int unsigned width, int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_nbit.sv
// Flat W-bit ripple adder used as the per-stage chunk adder.
module adder_nbit #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carry_in,
  output logic [W-1:0] sum,
  output logic         carry_out
);

  // Widen before adding so the carry out of the MSB is kept.
  assign {carry_out, sum} = (W+1)'(a) + (W+1)'(b) + (W+1)'(carry_in);

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined WIDTH-bit adder: one CHUNK-bit slice per stage, valid/ready on both ends.
module adder_pipe_nbit
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned STAGES   = DEF_STAGES,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  // Remaining operands are kept right-aligned: each stage consumes the low CHUNK bits.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] rem_a;
    logic [WIDTH-1:0] rem_b;
  } stage_t;

  if (!params_ok(WIDTH, STAGES)) begin : g_param_err
    $fatal(1, "adder_pipe_nbit: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  stage_t           stg_q   [STAGES];
  stage_t           stg_d   [STAGES];
  logic [CHUNK-1:0] add_a   [STAGES];
  logic [CHUNK-1:0] add_b   [STAGES];
  logic [CHUNK-1:0] add_sum [STAGES];
  logic             add_cin [STAGES];
  logic             add_cout[STAGES];
  logic             advance;

  // Whole pipe moves together whenever the output slot is empty or being drained.
  assign advance  = ~stg_q[STAGES-1].valid | out_ready;
  assign in_ready = advance;

  // Select each chunk adder's operands: live inputs for stage 1, delayed slices after that.
  always_comb begin
    add_a[0]   = a[CHUNK-1:0];
    add_b[0]   = b[CHUNK-1:0];
    add_cin[0] = carry_in;
    for (int i = 1; i < int'(STAGES); i++) begin
      add_a[i]   = stg_q[i-1].rem_a[CHUNK-1:0];
      add_b[i]   = stg_q[i-1].rem_b[CHUNK-1:0];
      add_cin[i] = stg_q[i-1].carry;
    end
  end

  for (genvar g = 0; g < int'(STAGES); g++) begin : g_chunk
    adder_nbit #(.W(CHUNK)) u_add (
      .a        (add_a[g]),
      .b        (add_b[g]),
      .carry_in (add_cin[g]),
      .sum      (add_sum[g]),
      .carry_out(add_cout[g])
    );
  end

  // Next contents of every stage; saturation is folded into the last stage's load.
  always_comb begin
    for (int i = 0; i < int'(STAGES); i++) begin
      stg_d[i] = '0;
    end
    stg_d[0].valid = in_valid;
    stg_d[0].carry = add_cout[0];
    stg_d[0].sum   = WIDTH'(add_sum[0]);
    stg_d[0].rem_a = a >> CHUNK;
    stg_d[0].rem_b = b >> CHUNK;
    for (int i = 1; i < int'(STAGES); i++) begin
      stg_d[i].valid                 = stg_q[i-1].valid;
      stg_d[i].carry                 = add_cout[i];
      stg_d[i].sum                   = stg_q[i-1].sum;
      stg_d[i].sum[i*CHUNK +: CHUNK] = add_sum[i];
      stg_d[i].rem_a                 = stg_q[i-1].rem_a >> CHUNK;
      stg_d[i].rem_b                 = stg_q[i-1].rem_b >> CHUNK;
    end
    if ((SATURATE != 0) && stg_d[STAGES-1].carry) begin
      stg_d[STAGES-1].sum = '1;
    end
  end

  // Stage registers: cleared by reset, shifted together on advance, held otherwise.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stg_q[i] <= '0;
      end
    end else if (advance) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stg_q[i] <= stg_d[i];
      end
    end
  end

  assign out_valid = stg_q[STAGES-1].valid;
  assign sum       = stg_q[STAGES-1].sum;
  assign overflow  = stg_q[STAGES-1].carry;

  // Accepted operands must be fully known.
  a_known_operands : assert property (
    @(posedge clk) disable iff (!n_rst)
    (in_valid && in_ready) |-> !$isunknown({a, b, carry_in})
  ) else $error("adder_pipe_nbit: X/Z on a, b or carry_in during accepted transfer");

endmodule
